// File: rtl/program_loader_pkg.sv
// Shared ISA constants and loader state encoding for the instruction front end.
package program_loader_pkg;
  localparam int PC_WIDTH    = 12;
  localparam int INSTR_WIDTH = 16;
  localparam int DEPTH       = 1 << PC_WIDTH;
  localparam int CNT_WIDTH   = PC_WIDTH + 1;

  localparam logic [INSTR_WIDTH-1:0] ISA_NOP = 16'h0000;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} loader_state_t;
endpackage

// File: rtl/instr_ram.sv
// Instruction store: one write port, one registered read port, plus a per-word
// valid vector with bulk clear so stale words from a previous program read as invalid.
module instr_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);
  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] vld;

  // No reset on the array so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (clr)     vld        <= '0;
    else if (we) vld[waddr] <= 1'b1;
    rvalid <= vld[raddr];
  end
endmodule

// File: rtl/program_loader.sv
// Streams a program into instruction memory while holding the core in reset,
// then serves registered fetches for the core's program counter.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH_P = DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  input  logic                   reload,
  input  logic [PC_WIDTH-1:0]    program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   core_rst,
  output logic                   loaded,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   word_count
);
  loader_state_t state, state_nxt;

  logic [PC_WIDTH-1:0]    wr_ptr;
  logic                   accept, at_end, clr, run_q;
  logic [INSTR_WIDTH-1:0] ram_q;
  logic                   ram_vld;

  // A reload in the same cycle as a handshake drops the word.
  assign accept = load_valid & load_ready & ~reload;
  assign at_end = (wr_ptr == PC_WIDTH'(DEPTH_P - 1));
  assign clr    = rst | reload | (state == EMPTY);

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   state_nxt = LOAD;
      LOAD:    if (reload) state_nxt = LOAD;
               else if (accept && (load_last || at_end)) state_nxt = RUN;
      RUN:     if (reload) state_nxt = LOAD;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_ready <= 1'b0;
      run_q      <= 1'b0;
      wr_ptr     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      load_ready <= (state_nxt == LOAD);
      run_q      <= (state == RUN);
      if (reload) begin
        wr_ptr     <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (word_count != CNT_WIDTH'(DEPTH_P)) word_count <= word_count + 1'b1;
        if (at_end && !load_last) overflow <= 1'b1;
      end
    end
  end

  instr_ram #(.DEPTH(DEPTH_P), .AW(PC_WIDTH), .DW(INSTR_WIDTH)) u_ram (
    .clk    (clk),
    .clr    (clr),
    .we     (accept),
    .waddr  (wr_ptr),
    .wdata  (load_data),
    .raddr  (program_counter),
    .rdata  (ram_q),
    .rvalid (ram_vld)
  );

  assign instruction = (run_q && ram_vld) ? ram_q : ISA_NOP;
  assign core_rst    = rst | (state != RUN);
  assign loaded      = (state == RUN);
endmodule

// File: doc/program_loader.md
# program_loader

Instruction-side front end that sits directly upstream of the control/multiprocessor pair. It accepts a program as a valid/ready stream of 16-bit words and writes it into an internal 4096×16 instruction memory. During loading it holds the downstream core in reset. Once loading ends it serves `instruction` for every `program_counter` value the core presents.

## Interface
- `DEPTH`, 4096: instruction memory words; must equal 2^`PC_WIDTH`.
- `PC_WIDTH`, 12: program counter width.
- `INSTR_WIDTH`, 16: instruction width.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  stream word present.
- `load_ready`  out  1  loader accepts a word this cycle.
- `load_data`  in  16  program word.
- `load_last`  in  1  marks the final word of the program; valid only with `load_valid`.
- `reload`  in  1  single-cycle request to discard the program and load again.
- `program_counter`  in  12  fetch address from the control unit.
- `instruction`  out  16  fetched word for the control unit and multiprocessor.
- `core_rst`  out  1  reset for the downstream control unit and multiprocessor.
- `loaded`  out  1  a complete program is resident.
- `overflow`  out  1  sticky flag: the stream exceeded `DEPTH` words.
- `word_count`  out  13  number of words written in the current load.

## Operation
- States:
  - EMPTY: reset state.
  - LOAD
  - RUN
- EMPTY -> LOAD: unconditional on the first cycle after `rst` deasserts.
- LOAD:
  - `load_ready`=1.
  - A word is accepted when `load_valid & load_ready`.
  - Each accepted word writes `mem[wr_ptr]`, then increments `wr_ptr` and `word_count`.
- LOAD -> RUN on either event:
  - An accepted word carries `load_last`=1.
  - The accepted word is at `wr_ptr`=`DEPTH`-1 with `load_last`=0. This case is a forced end: `overflow` sets and stays set until `rst` or `reload`.
- Any address not written in the current load reads `ISA_NOP`: a per-word valid bit is cleared on entry to LOAD.
- RUN:
  - `load_ready`=0.
  - `instruction` = `mem[program_counter]`, or `ISA_NOP` if that word's valid bit is clear.
- `reload` in any state except EMPTY:
  - Next state is LOAD.
  - Clears `wr_ptr`, `word_count`, `loaded`, `overflow` and all valid bits.
- `reload` asserted in the same cycle as an accepted word: `reload` wins and the word is dropped.
- `core_rst` = `rst` | (state != RUN).
- `loaded` = (state == RUN).

## Timing
- Reset values:
  - `load_ready`=0
  - `instruction`=`ISA_NOP`
  - `core_rst`=1
  - `loaded`=0
  - `overflow`=0
  - `word_count`=0
  - state EMPTY
- `load_ready` is a registered state decode and does not depend on `load_valid`.
- Write latency: a word accepted at edge N is readable from edge N+1.
- Read latency is one cycle:
  - `program_counter` sampled at edge N gives `instruction` valid after edge N.
  - The control unit is built for a registered fetch.
- Outside RUN, `instruction` is forced to `ISA_NOP` after the next edge.
- LOAD->RUN transition:
  - `core_rst` falls at the same edge as `loaded` rises.
  - The first fetch, of address 0, returns its word one cycle later.
- Mid-operation `rst` takes effect at the next edge and returns all outputs to their reset values. Memory contents may persist, but all valid bits clear.
- `word_count` saturates at `DEPTH` (13 bits) and never wraps.

## Structure
- Put `ISA_NOP` (16'h0000), `PC_WIDTH` and `INSTR_WIDTH` in the shared ISA package; do not redefine them locally.
- Put the loader state enum `loader_state_t` {EMPTY, LOAD, RUN} in the same package so the top level and the bench can decode it.
- Sub-module `instr_ram`:
  - Single write port, single registered read port, `DEPTH`×`INSTR_WIDTH`, plus the valid-bit vector with a bulk clear.
  - It maps to block RAM on FPGA targets.
- The FSM and counters live in `program_loader` itself.

## Test plan
- Basic load: stream 0x1111, 0x2222, 0x3333 (last) with `load_valid` held high.
  - `word_count`=3.
  - `loaded`=1 and `core_rst`=0 at the edge after the third word.
  - PC=1 returns 0x2222 one cycle later.
  - PC=5 returns 0x0000.
- Backpressure and bubbles: toggle `load_valid` randomly over a 10-word program.
  - Exactly 10 words are stored, in order.
  - No word is accepted while `load_ready`=0.
- Overflow: stream 4097 words with no `load_last`.
  - RUN is entered after word 4096 and `overflow`=1.
  - `word_count`=4096.
  - PC=4095 returns the 4096th word.
- Reload: in RUN, pulse `reload`, then load 2 words.
  - `core_rst` reasserts on the next cycle.
  - PC=2 returns `ISA_NOP`, not the old program's word.
  - `overflow` is cleared.
- Collision: `reload` in the same cycle as an accepted `load_last` word.
  - State is LOAD.
  - `word_count`=0.
  - The word is dropped.
- Mid-load reset: assert `rst` after 3 words.
  - All outputs return to their reset values on the next edge.
  - A following 1-word load makes PC=1 read `ISA_NOP`.
